// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART-to-SRAM loader
package uart_loader_pkg;

  localparam int ADDR_W  = 18;
  localparam int TIMER_W = 26;

  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_WRITE,
    S_DONE
  } loader_state_t;

endpackage

// File: rtl/loader_idle_timer.sv
// rtl/loader_idle_timer.sv - armable, reloadable idle counter with expire flag
module loader_idle_timer
  import uart_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_arm,
  input  logic i_reload,
  output logic o_expire
);

  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic               r_armed;
  logic [TIMER_W-1:0] r_count;

  // Counting stops at the last value so expire holds until the next clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed <= 1'b0;
      r_count <= '0;
    end else if (i_clr) begin
      r_armed <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_arm) begin
        r_armed <= 1'b1;
      end
      if (i_reload) begin
        r_count <= '0;
      end else if (r_armed && (r_count != LAST_COUNT)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_expire = r_armed && (r_count == LAST_COUNT);

endmodule

// File: rtl/uart_sram_loader.sv
// rtl/uart_sram_loader.sv - packs UART byte pairs into big-endian words and writes them to SRAM
module uart_sram_loader
  import uart_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 18'd76800,
  parameter int                MAX_WORDS      = 185344,
  parameter int                TIMEOUT_CYCLES = 50000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_rx_frame_error,
  output logic [ADDR_W-1:0] o_sram_address,
  output logic [15:0]       o_sram_write_data,
  output logic              o_sram_we_n,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_word_count,
  output logic [7:0]        o_error_count
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MAX_WORDS - 1);

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W-1:0] r_word_count;
  logic [15:0]       r_write_data;
  logic              r_we_n;
  logic              r_busy;
  logic              r_done;
  logic              r_pad_write;
  logic [7:0]        r_hi_byte;
  logic              r_skid_valid;
  logic [7:0]        r_skid_data;
  logic              r_skid_error;
  logic [7:0]        r_error_count;

  logic       w_start;
  logic       w_in_wait;
  logic       w_use_skid;
  logic       w_byte_valid;
  logic [7:0] w_byte_data;
  logic       w_byte_error;
  logic       w_good;
  logic       w_bad;
  logic       w_expire;

  assign w_start   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_in_wait = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);

  // A byte parked during the write cycle stands in for the live input in S_WAIT_HI.
  assign w_use_skid   = (r_state == S_WAIT_HI) && r_skid_valid;
  assign w_byte_valid = w_use_skid ? 1'b1         : i_rx_valid;
  assign w_byte_data  = w_use_skid ? r_skid_data  : i_rx_data;
  assign w_byte_error = w_use_skid ? r_skid_error : i_rx_frame_error;

  assign w_good = w_in_wait && w_byte_valid && !w_byte_error;
  assign w_bad  = w_in_wait && w_byte_valid && w_byte_error;

  loader_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start),
    .i_arm   (w_good),
    .i_reload(i_rx_valid && r_busy),
    .o_expire(w_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_address     <= BASE_ADDR;
      r_word_count  <= '0;
      r_write_data  <= '0;
      r_we_n        <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pad_write   <= 1'b0;
      r_hi_byte     <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_data   <= '0;
      r_skid_error  <= 1'b0;
      r_error_count <= '0;
    end else begin
      if (w_bad && (r_error_count != 8'hFF)) begin
        r_error_count <= r_error_count + 1'b1;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_address     <= BASE_ADDR;
            r_word_count  <= '0;
            r_error_count <= '0;
            r_pad_write   <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_state       <= S_WAIT_HI;
          end
        end

        S_WAIT_HI: begin
          r_skid_valid <= 1'b0;
          if (w_good) begin
            r_hi_byte <= w_byte_data;
            r_state   <= S_WAIT_LO;
          end else if (!w_byte_valid && w_expire) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_WAIT_LO: begin
          if (w_good) begin
            r_we_n       <= 1'b0;
            r_write_data <= {r_hi_byte, w_byte_data};
            r_state      <= S_WRITE;
          end else if (!i_rx_valid && w_expire) begin
            r_we_n       <= 1'b0;
            r_write_data <= {r_hi_byte, PAD_BYTE};
            r_pad_write  <= 1'b1;
            r_state      <= S_WRITE;
          end
        end

        S_WRITE: begin
          r_we_n       <= 1'b1;
          r_address    <= r_address + 1'b1;
          r_word_count <= r_word_count + 1'b1;
          if (i_rx_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_rx_data;
            r_skid_error <= i_rx_frame_error;
          end
          if (r_pad_write || (r_word_count == LAST_WORD)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_WAIT_HI;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_sram_address    = r_address;
  assign o_sram_write_data = r_write_data;
  assign o_sram_we_n       = r_we_n;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_word_count      = r_word_count;
  assign o_error_count     = r_error_count;

endmodule

// File: doc/uart_sram_loader.md
Name: uart_sram_loader

Overview:
Upstream stage of the decompressor. Takes bytes from the UART receiver, packs each pair into one big-endian 16-bit word and writes the words to external SRAM. Writing starts at BASE_ADDR, one word per address. The block asserts done after an idle timeout or after MAX_WORDS words; the top-level FSM then leaves its UART state and starts milestone 3.

Parameters:
BASE_ADDR, 18'd76800, first SRAM word address written (start of the compressed-stream region)
MAX_WORDS, 185344, word limit (fills the SRAM to address 262143)
TIMEOUT_CYCLES, 50000000, idle cycles after the last accepted byte before done (1 s at 50 MHz)

Ports:
Clock  in  1  50 MHz system clock
Resetn  in  1  asynchronous active-low reset
Start  in  1  one-cycle pulse; arms the loader
RX_data  in  8  received byte
RX_valid  in  1  one-cycle strobe, RX_data valid
RX_frame_error  in  1  qualifies RX_valid; byte is corrupt
SRAM_address  out  18  write address
SRAM_write_data  out  16  write data
SRAM_we_n  out  1  active-low write enable
Busy  out  1  high from Start until done
Done  out  1  level, high in S_DONE
Word_count  out  18  words written in the current load
Error_count  out  8  dropped bytes, saturates at 255

Behaviour:
- Reset values: SRAM_address=BASE_ADDR, SRAM_write_data=0, SRAM_we_n=1, Busy=0, Done=0, Word_count=0, Error_count=0. All internal registers are cleared. Reset asserted mid-load aborts the load immediately; no write completes after reset.
- States:
  - S_IDLE: on Start, clear the counters and timer, set the address to BASE_ADDR, go to S_WAIT_HI.
  - S_WAIT_HI: a good byte latches into hi_byte; go to S_WAIT_LO.
  - S_WAIT_LO: a good byte goes to S_WRITE with data {hi_byte, RX_data}.
  - S_WRITE: SRAM_we_n=0 for exactly one cycle with the address and data registered. On the next cycle SRAM_address and Word_count both increment. If Word_count reaches MAX_WORDS, go to S_DONE; otherwise go to S_WAIT_HI.
  - S_DONE: Done=1, Busy=0. Start re-arms (returns to S_WAIT_HI via the S_IDLE actions).
- Latency: the write is issued in the cycle after the low byte's RX_valid; we_n is low 1 cycle after that strobe edge.
- Only bytes with RX_valid=1 and RX_frame_error=0 are accepted. A byte with RX_frame_error=1 is dropped, increments Error_count (saturating) and does not advance the state. It does reload the timeout.
- RX_valid in S_IDLE or S_DONE is ignored with no count change. RX_valid in S_WRITE is held in a 1-entry skid register and processed in S_WAIT_HI; a second overlapping strobe is impossible at UART rates. Start while Busy is ignored.
- Timeout:
  - A 26-bit timer is armed on the first accepted byte of a load. It is reloaded to 0 on every RX_valid and increments otherwise.
  - No timeout before the first byte; the loader waits indefinitely.
  - Timer reaches TIMEOUT_CYCLES-1 in S_WAIT_HI: go to S_DONE.
  - Timer reaches TIMEOUT_CYCLES-1 in S_WAIT_LO (odd byte count): write {hi_byte, 8'h00}, then go to S_DONE.
  - Timeout and RX_valid in the same cycle: RX_valid wins and the timer reloads.
- Address wrap: none. MAX_WORDS stops the load before 18-bit overflow. A byte arriving after the limit is ignored.
- The block never writes outside [BASE_ADDR, BASE_ADDR+MAX_WORDS-1].
- Busy = state is in {S_WAIT_HI, S_WAIT_LO, S_WRITE}.

Decomposition:
- Package uart_loader_pkg holds:
  - loader_state_t enum {S_IDLE, S_WAIT_HI, S_WAIT_LO, S_WRITE, S_DONE}
  - localparams ADDR_W=18 and TIMER_W=26
  - the pad byte constant 8'h00
- One sub-module, loader_idle_timer: an armable reloadable counter with expire output, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Start, then bytes 0x12,0x34,0xAB,0xCD -> we_n low twice: addr 76800 data 0x1234, addr 76801 data 0xABCD; Word_count=2.
2. Three bytes 0x01,0x02,0x03, then idle, run with TIMEOUT_CYCLES=1000 -> writes 0x0102@76800, then 0x0300@76801 at 1000 cycles after the last byte; Done=1, Word_count=2.
3. Byte 0x55 with RX_frame_error=1, then 0xAA,0xBB -> single write 0xAABB@76800, Error_count=1.
4. MAX_WORDS=4 with 10 bytes streamed -> exactly 4 writes at 76800..76803; Done=1 after the 4th write; remaining bytes ignored, no out-of-region write.
5. Resetn pulled low between the hi and lo bytes -> all outputs at reset values, no write; after Start, the next pair writes to 76800.
6. No bytes after Start for 2*TIMEOUT_CYCLES -> Done stays 0, Busy stays 1; RX_valid coincident with timer expiry -> no Done, byte accepted.
